kbd_scancode_ctrl: RTL
======================

// Module: kbd_scancode_ctrl
// PURPOSE
//  Consumes PS/2 scan-code bytes from the ps2_keyboard receive FIFO and turns them into key events.
//  Tracks the currently held key (make/break, E0 extended prefix) and suppresses typematic repeats.
//  Counts distinct key presses and provides an ASCII translation of the held key.
//  Outputs feed the seg display path (press count, keycode, ASCII) in the board top level.
// PARAMETERS
//  COUNT_W   8   width of press_count; the counter wraps modulo 2**COUNT_W
// PORTS
//  clk            in   1        system clock, single clock domain
//  rst            in   1        synchronous reset, active-high
//  kb_data        in   8        FIFO head byte from ps2_keyboard (valid while kb_ready=1)
//  kb_ready       in   1        FIFO non-empty
//  kb_overflow    in   1        FIFO overflow flag from ps2_keyboard
//  kb_nextdata_n  out  1        active-low pop strobe to the FIFO, one cycle per byte
//  key_valid      out  1        a key is currently held
//  key_code       out  8        scan code of held/last key
//  key_ext        out  1        held/last key was E0-prefixed
//  key_ascii      out  8        ASCII of key_code; 8'h00 if extended or unmapped
//  key_press      out  1        one-cycle pulse on a new make event
//  key_release    out  1        one-cycle pulse on a matching break event
//  press_count    out  COUNT_W  number of new make events since reset
//  err_overflow   out  1        sticky; set when kb_overflow is seen, cleared only by rst
// BEHAVIOUR
//  Reset values: kb_nextdata_n=1, key_valid=0, key_code=8'h00, key_ext=0, key_ascii=8'h00,
//   key_press=0, key_release=0, press_count=0, err_overflow=0, both prefix flags=0, state=IDLE.
//   A reset mid-sequence discards any captured byte and pending prefixes; nothing is popped.
//  FSM (3 states, every transition on the clk edge):
//   IDLE: if kb_ready, register kb_data, drive kb_nextdata_n<=0, and go to POP. Otherwise stay.
//   POP : kb_nextdata_n<=1, decode the registered byte, go to WAIT.
//   WAIT: one settle cycle so the FIFO's ready can update, then go to IDLE.
//   Throughput is 1 byte per 3 cycles. Outputs reflect a byte 2 edges after kb_ready is sampled in IDLE.
//  Decode (in POP):
//   8'hE0 -> ext_pend<=1. No output change.
//   8'hF0 -> brk_pend<=1. No output change.
//   other code c, with e=ext_pend:
//    brk_pend=1: if key_valid && c==key_code && e==key_ext, then key_valid<=0 and pulse key_release.
//     Otherwise ignore the byte; key_code and key_ext are unchanged.
//    brk_pend=0: if key_valid && c==key_code && e==key_ext, this is a typematic repeat:
//     no pulse and no count.
//     Otherwise key_code<=c, key_ext<=e, key_valid<=1, pulse key_press, press_count<=press_count+1
//     (wraps to 0).
//    Both prefix flags clear after any non-prefix byte.
//  Boundary cases:
//   - E0 F0 xx is an extended break.
//   - F0 E0 xx is handled the same way: the prefixes are order-insensitive.
//   - A new make while another key is held replaces it (last key wins) and counts.
//   - key_ascii is a registered lookup of key_code/key_ext, updated in the same cycle as key_code.
//   - kb_overflow=1 in any cycle sets err_overflow and also clears ext_pend/brk_pend that cycle,
//     since the byte stream is no longer trusted. Decoding continues.
//   - kb_ready dropping while in POP or WAIT has no effect; the next byte is taken only from IDLE.
//   - key_press and key_release are never both asserted in the same cycle.
// STRUCTURE
//  kbd_defs.vh (shared include): SC_EXT=8'hE0, SC_BREAK=8'hF0, FSM encodings ST_IDLE/ST_POP/ST_WAIT.
//  Sub-module scancode_ascii: combinational ROM with inputs code[7:0] and ext, output ascii[7:0].
//   It covers set-2 letters, digits, space, enter, and backspace, returns 8'h00 for everything else,
//   and is reusable by the display path.
//  Top level wiring: ps2_keyboard.data/ready/nextdata_n/overflow <-> kb_*;
//   press_count and key_code drive the seg digits.
// TESTING
//  1 Press/release "A": bytes 1C, F0, 1C.
//    -> key_press 1 cycle, key_code=1C, key_ascii=8'h61, press_count=1;
//       then key_release pulse, key_valid=0.
//  2 Typematic: bytes 1C, 1C, 1C, F0, 1C.
//    -> exactly one key_press, press_count=1, one key_release.
//  3 Extended: bytes E0, 75, E0, F0, 75.
//    -> key_code=75, key_ext=1, key_ascii=00, press_count=1, key_release on the last byte.
//    The non-extended sequence 75, F0, E0, 75 must NOT release the held key.
//  4 Handshake: hold kb_ready=1 with 4 queued bytes.
//    -> kb_nextdata_n is low for exactly 1 cycle every 3 cycles, and 4 pops total.
//    Also check: a byte arriving during POP/WAIT is never double-popped.
//  5 Wrap and rollover:
//    - 256 distinct make/break pairs with COUNT_W=8 -> press_count returns to 0.
//    - Make 1C, then make 32 without a break -> second key_press, key_code=32, press_count=2.
//  6 Reset/overflow:
//    - Assert rst after E0, F0 -> all outputs return to reset values; a following 75 is a plain make.
//    - Pulse kb_overflow -> err_overflow=1 held until rst.

Source files
------------

// File: rtl/kbd_scancode_ctrl_pkg.sv
// Shared definitions for the PS/2 scan-code controller and its helpers.
//   SC_EXT    : set-2 extended-key prefix byte
//   SC_BREAK  : set-2 break (key released) prefix byte
//   state_e   : byte-handshake FSM states (IDLE -> POP -> WAIT -> IDLE)
package kbd_scancode_ctrl_pkg;

    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BREAK = 8'hF0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_POP  = 2'd1,
        ST_WAIT = 2'd2
    } state_e;

endpackage

// File: rtl/kbd_scancode_ctrl_ascii.sv
// scancode_ascii: combinational set-2 scan code to ASCII lookup.
//   code_i  [7:0] : set-2 make code
//   ext_i         : code was E0-prefixed (extended keys never map)
//   ascii_o [7:0] : lowercase letters, digits, space, CR, BS; 8'h00 otherwise
module scancode_ascii (
    input  logic [7:0] code_i,
    input  logic       ext_i,
    output logic [7:0] ascii_o
);

    always_comb begin
        ascii_o = 8'h00;
        if (!ext_i) begin
            case (code_i)
                8'h1C: ascii_o = 8'h61; // a
                8'h32: ascii_o = 8'h62; // b
                8'h21: ascii_o = 8'h63; // c
                8'h23: ascii_o = 8'h64; // d
                8'h24: ascii_o = 8'h65; // e
                8'h2B: ascii_o = 8'h66; // f
                8'h34: ascii_o = 8'h67; // g
                8'h33: ascii_o = 8'h68; // h
                8'h43: ascii_o = 8'h69; // i
                8'h3B: ascii_o = 8'h6A; // j
                8'h42: ascii_o = 8'h6B; // k
                8'h4B: ascii_o = 8'h6C; // l
                8'h3A: ascii_o = 8'h6D; // m
                8'h31: ascii_o = 8'h6E; // n
                8'h44: ascii_o = 8'h6F; // o
                8'h4D: ascii_o = 8'h70; // p
                8'h15: ascii_o = 8'h71; // q
                8'h2D: ascii_o = 8'h72; // r
                8'h1B: ascii_o = 8'h73; // s
                8'h2C: ascii_o = 8'h74; // t
                8'h3C: ascii_o = 8'h75; // u
                8'h2A: ascii_o = 8'h76; // v
                8'h1D: ascii_o = 8'h77; // w
                8'h22: ascii_o = 8'h78; // x
                8'h35: ascii_o = 8'h79; // y
                8'h1A: ascii_o = 8'h7A; // z
                8'h45: ascii_o = 8'h30; // 0
                8'h16: ascii_o = 8'h31; // 1
                8'h1E: ascii_o = 8'h32; // 2
                8'h26: ascii_o = 8'h33; // 3
                8'h25: ascii_o = 8'h34; // 4
                8'h2E: ascii_o = 8'h35; // 5
                8'h36: ascii_o = 8'h36; // 6
                8'h3D: ascii_o = 8'h37; // 7
                8'h3E: ascii_o = 8'h38; // 8
                8'h46: ascii_o = 8'h39; // 9
                8'h29: ascii_o = 8'h20; // space
                8'h5A: ascii_o = 8'h0D; // enter
                8'h66: ascii_o = 8'h08; // backspace
                default: ascii_o = 8'h00;
            endcase
        end
    end

endmodule

// File: rtl/kbd_scancode_ctrl.sv
// kbd_scancode_ctrl: pops PS/2 set-2 bytes from the keyboard FIFO and turns
// them into held-key state, press/release pulses and a press counter.
//   clk_i, rst_i        : clock, synchronous active-high reset
//   kb_data_i/ready_i   : FIFO head byte and non-empty flag
//   kb_overflow_i       : FIFO overflow flag
//   kb_nextdata_n_o     : active-low one-cycle pop strobe
//   key_valid/code/ext/ascii_o : held (or last) key and its ASCII
//   key_press/release_o : one-cycle event pulses
//   press_count_o       : new make events since reset (wraps)
//   err_overflow_o      : sticky overflow flag
module kbd_scancode_ctrl
    import kbd_scancode_ctrl_pkg::*;
#(
    parameter int COUNT_W = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [7:0]         kb_data_i,
    input  logic               kb_ready_i,
    input  logic               kb_overflow_i,
    output logic               kb_nextdata_n_o,
    output logic               key_valid_o,
    output logic [7:0]         key_code_o,
    output logic               key_ext_o,
    output logic [7:0]         key_ascii_o,
    output logic               key_press_o,
    output logic               key_release_o,
    output logic [COUNT_W-1:0] press_count_o,
    output logic               err_overflow_o
);

    state_e             state_q, state_d;
    logic [7:0]         byte_q, byte_d;
    logic               nd_q, nd_d;
    logic               valid_q, valid_d;
    logic [7:0]         code_q, code_d;
    logic               ext_q, ext_d;
    logic [7:0]         ascii_q, ascii_d;
    logic               press_q, press_d;
    logic               release_q, release_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic               err_q, err_d;
    logic               ext_pend_q, ext_pend_d;
    logic               brk_pend_q, brk_pend_d;
    logic               same_key;

    // Same physical key as the one currently held (code and extension both match).
    assign same_key = valid_q && (byte_q == code_q) && (ext_pend_q == ext_q);

    always_comb begin
        state_d    = state_q;
        byte_d     = byte_q;
        nd_d       = nd_q;
        valid_d    = valid_q;
        code_d     = code_q;
        ext_d      = ext_q;
        count_d    = count_q;
        err_d      = err_q;
        ext_pend_d = ext_pend_q;
        brk_pend_d = brk_pend_q;
        press_d    = 1'b0;
        release_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (kb_ready_i) begin
                    byte_d  = kb_data_i;
                    nd_d    = 1'b0;
                    state_d = ST_POP;
                end
            end
            ST_POP: begin
                nd_d    = 1'b1;
                state_d = ST_WAIT;
                if (byte_q == SC_EXT) begin
                    ext_pend_d = 1'b1;
                end else if (byte_q == SC_BREAK) begin
                    brk_pend_d = 1'b1;
                end else begin
                    if (brk_pend_q) begin
                        // Breaks for any key other than the held one are dropped.
                        if (same_key) begin
                            valid_d   = 1'b0;
                            release_d = 1'b1;
                        end
                    end else if (!same_key) begin
                        // Repeats of the held key are typematic and ignored.
                        code_d  = byte_q;
                        ext_d   = ext_pend_q;
                        valid_d = 1'b1;
                        press_d = 1'b1;
                        count_d = count_q + COUNT_W'(1);
                    end
                    ext_pend_d = 1'b0;
                    brk_pend_d = 1'b0;
                end
            end
            ST_WAIT: begin
                // Give the FIFO a cycle to update its ready flag after the pop.
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                nd_d    = 1'b1;
            end
        endcase

        // After an overflow the prefix context can no longer be trusted.
        if (kb_overflow_i) begin
            err_d      = 1'b1;
            ext_pend_d = 1'b0;
            brk_pend_d = 1'b0;
        end
    end

    // ASCII is looked up from the next key so it changes on the same edge as key_code.
    scancode_ascii u_ascii (
        .code_i  (code_d),
        .ext_i   (ext_d),
        .ascii_o (ascii_d)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            nd_q       <= 1'b1;
            valid_q    <= 1'b0;
            code_q     <= 8'h00;
            ext_q      <= 1'b0;
            ascii_q    <= 8'h00;
            press_q    <= 1'b0;
            release_q  <= 1'b0;
            count_q    <= '0;
            err_q      <= 1'b0;
            ext_pend_q <= 1'b0;
            brk_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            nd_q       <= nd_d;
            valid_q    <= valid_d;
            code_q     <= code_d;
            ext_q      <= ext_d;
            ascii_q    <= ascii_d;
            press_q    <= press_d;
            release_q  <= release_d;
            count_q    <= count_d;
            err_q      <= err_d;
            ext_pend_q <= ext_pend_d;
            brk_pend_q <= brk_pend_d;
        end
        byte_q <= byte_d;
    end

    assign kb_nextdata_n_o = nd_q;
    assign key_valid_o     = valid_q;
    assign key_code_o      = code_q;
    assign key_ext_o       = ext_q;
    assign key_ascii_o     = ascii_q;
    assign key_press_o     = press_q;
    assign key_release_o   = release_q;
    assign press_count_o   = count_q;
    assign err_overflow_o  = err_q;

endmodule
